// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for the shared ALU.
// It takes one request at a time, issues it to the ALU with a start/done
// handshake and returns the result and flags to the requester that was granted.
// Requests with an invalid op code, and ALU operations that run too long, are
// answered locally with an error response.
module alu_arbiter #(
  parameter int unsigned WIDTH   = 16,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] OP_MAX = 4'd9;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             alu_start_q, alu_start_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic             rsp_err_q, rsp_err_d;

  logic             grant_sel;
  logic             accept;
  logic [1:0]       sel_onehot;
  logic [1:0]       rsp_onehot;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_op;
  logic             timeout_hit;
  logic             rsp_taken;

  // Arbitration: sole valid requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_sel = 1'b0;
    case (req_valid)
      2'b10:   grant_sel = 1'b1;
      2'b11:   grant_sel = ~last_grant_q;
      default: grant_sel = 1'b0;
    endcase
    accept      = (state_q == IDLE) && (|req_valid) && !RST;
    sel_onehot  = grant_sel ? 2'b10 : 2'b01;
    req_ready   = accept ? sel_onehot : 2'b00;
    sel_a       = grant_sel ? req1_a  : req0_a;
    sel_b       = grant_sel ? req1_b  : req0_b;
    sel_op      = grant_sel ? req1_op : req0_op;
    rsp_onehot  = grant_q ? 2'b10 : 2'b01;
    timeout_hit = (cnt_q == (TIMEOUT - 8'd1));
    rsp_taken   = grant_q ? rsp_ready[1] : rsp_ready[0];
  end

  // State register; reset drops any request in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic for the issue/wait/respond sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (sel_op <= OP_MAX) ? ISSUE : RESP;
      ISSUE:   state_d = WAIT;
      WAIT:    if (alu_done || timeout_hit) state_d = RESP;
      RESP:    if (rsp_taken) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch the request, pulse start, capture or fake the response.
  always_comb begin
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_start_d  = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = grant_sel;
          grant_d      = grant_sel;
          alu_a_d      = sel_a;
          alu_b_d      = sel_b;
          alu_op_d     = sel_op;
          if (sel_op <= OP_MAX) begin
            alu_start_d = 1'b1;
          end else begin
            rsp_valid_d  = sel_onehot;
            rsp_result_d = '0;
            rsp_flags_d  = 4'b0000;
            rsp_err_d    = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_d = 8'd0;
      end
      WAIT: begin
        if (alu_done) begin
          rsp_valid_d  = rsp_onehot;
          rsp_result_d = alu_result;
          rsp_flags_d  = alu_flags;
          rsp_err_d    = 1'b0;
        end else if (timeout_hit) begin
          rsp_valid_d  = rsp_onehot;
          rsp_result_d = '0;
          rsp_flags_d  = 4'b0000;
          rsp_err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_taken) rsp_valid_d = 2'b00;
      end
      default: begin
        rsp_valid_d = 2'b00;
      end
    endcase
  end

  // Datapath registers; every output except req_ready comes straight from a flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= 8'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 4'd0;
      alu_start_q  <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'd0;
      rsp_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_start_q  <= alu_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_start  = alu_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter; the bench plays the ALU itself.
module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic [3:0]  alu_flags = '0;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.WIDTH(16), .TIMEOUT(8'd4)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags)
  );

  always #5 CLK = ~CLK;

  // Pulse reset for one cycle; leaves the caller on a falling edge with reset released.
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    req_valid = 2'b00; rsp_ready = 2'b00; alu_done = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid got=%b exp=%b", rsp_valid, 2'b00); end
    checks++; if (alu_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_alu_start got=%b exp=%b", alu_start, 1'b0); end
    checks++; if (rsp_result !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rsp_result got=%h exp=%h", rsp_result, 16'h0000); end
    checks++; if (alu_a !== 16'h0000) begin errors++; $display("[TB] FAIL reset_alu_a got=%h exp=%h", alu_a, 16'h0000); end
    req_valid = 2'b01; #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready got=%b exp=%b", req_ready, 2'b00); end
    req_valid = 2'b00; RST = 1'b0;
    @(negedge CLK);
    req_valid = 2'b01; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL reset_release_ready got=%b exp=%b", req_ready, 2'b01); end
    req_valid = 2'b00;
  endtask

  task automatic test_single_op();
    @(negedge CLK);
    req_valid = 2'b01; req0_op = 4'd0; req0_a = 16'h0003; req0_b = 16'h0004; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_ready got=%b exp=%b", req_ready, 2'b01); end
    @(negedge CLK);
    req_valid = 2'b00;
    checks++; if (alu_start !== 1'b1) begin errors++; $display("[TB] FAIL single_start got=%b exp=%b", alu_start, 1'b1); end
    checks++; if (alu_a !== 16'h0003 || alu_b !== 16'h0004 || alu_op !== 4'd0) begin errors++; $display("[TB] FAIL single_operands got=%h/%h/%h exp=0003/0004/0", alu_a, alu_b, alu_op); end
    @(negedge CLK);
    checks++; if (alu_start !== 1'b0) begin errors++; $display("[TB] FAIL single_start_pulse got=%b exp=%b", alu_start, 1'b0); end
    @(negedge CLK);
    alu_done = 1'b1; alu_result = 16'h0007; alu_flags = 4'b0000;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL single_early_rsp got=%b exp=%b", rsp_valid, 2'b00); end
    @(negedge CLK);
    alu_done = 1'b0;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL single_rsp_valid got=%b exp=%b", rsp_valid, 2'b01); end
    checks++; if (rsp_result !== 16'h0007 || rsp_flags !== 4'b0000 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL single_rsp_data got=%h/%b/%b exp=0007/0000/0", rsp_result, rsp_flags, rsp_err); end
    rsp_ready = 2'b01;
    @(negedge CLK);
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL single_rsp_drop got=%b exp=%b", rsp_valid, 2'b00); end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_onehot;
    logic [15:0] exp_a, exp_res;
    logic [3:0]  exp_op, exp_flags;
    do_reset();
    req0_op = 4'd1; req0_a = 16'h8000; req0_b = 16'h0001;
    req1_op = 4'd0; req1_a = 16'h1234; req1_b = 16'h0001;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_onehot = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a      = (k % 2 == 0) ? 16'h8000 : 16'h1234;
      exp_op     = (k % 2 == 0) ? 4'd1 : 4'd0;
      exp_res    = (k % 2 == 0) ? 16'h7FFF : 16'h1235;
      exp_flags  = (k % 2 == 0) ? 4'b1100 : 4'b0000;
      #1;
      checks++; if (req_ready !== exp_onehot) begin errors++; $display("[TB] FAIL fair_grant%0d got=%b exp=%b", k, req_ready, exp_onehot); end
      @(negedge CLK);
      checks++; if (alu_start !== 1'b1 || alu_a !== exp_a || alu_op !== exp_op) begin errors++; $display("[TB] FAIL fair_issue%0d got=%b/%h/%h exp=1/%h/%h", k, alu_start, alu_a, alu_op, exp_a, exp_op); end
      @(negedge CLK);
      alu_done = 1'b1; alu_result = exp_res; alu_flags = exp_flags;
      @(negedge CLK);
      alu_done = 1'b0;
      checks++; if (rsp_valid !== exp_onehot || rsp_result !== exp_res || rsp_flags !== exp_flags) begin errors++; $display("[TB] FAIL fair_rsp%0d got=%b/%h/%b exp=%b/%h/%b", k, rsp_valid, rsp_result, rsp_flags, exp_onehot, exp_res, exp_flags); end
      rsp_ready = 2'b11;
      @(negedge CLK);
      rsp_ready = 2'b00;
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL fair_rsp_drop%0d got=%b exp=%b", k, rsp_valid, 2'b00); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_invalid_op();
    @(negedge CLK);
    req_valid = 2'b10; req1_op = 4'hB; req1_a = 16'h5555; req1_b = 16'hAAAA; #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL inv_ready got=%b exp=%b", req_ready, 2'b10); end
    @(negedge CLK);
    req_valid = 2'b00;
    checks++; if (alu_start !== 1'b0) begin errors++; $display("[TB] FAIL inv_no_start got=%b exp=%b", alu_start, 1'b0); end
    checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL inv_rsp got=%b/%b exp=10/1", rsp_valid, rsp_err); end
    checks++; if (rsp_result !== 16'h0000 || rsp_flags !== 4'b0000) begin errors++; $display("[TB] FAIL inv_rsp_data got=%h/%b exp=0000/0000", rsp_result, rsp_flags); end
    rsp_ready = 2'b01;
    @(negedge CLK);
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("[TB] FAIL inv_other_ready got=%b exp=%b", rsp_valid, 2'b10); end
    rsp_ready = 2'b10;
    @(negedge CLK);
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00 || alu_start !== 1'b0) begin errors++; $display("[TB] FAIL inv_done got=%b/%b exp=00/0", rsp_valid, alu_start); end
  endtask

  task automatic test_timeout();
    @(negedge CLK);
    req_valid = 2'b01; req0_op = 4'd0; req0_a = 16'h0005; req0_b = 16'h0006; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL to_ready got=%b exp=%b", req_ready, 2'b01); end
    @(negedge CLK);
    req_valid = 2'b00;
    checks++; if (alu_start !== 1'b1) begin errors++; $display("[TB] FAIL to_start got=%b exp=%b", alu_start, 1'b1); end
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      checks++; if (rsp_valid !== 2'b00 || alu_start !== 1'b0) begin errors++; $display("[TB] FAIL to_waiting%0d got=%b/%b exp=00/0", c, rsp_valid, alu_start); end
    end
    @(negedge CLK);
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_result !== 16'h0000 || rsp_flags !== 4'b0000) begin errors++; $display("[TB] FAIL to_rsp got=%b/%b/%h/%b exp=01/1/0000/0000", rsp_valid, rsp_err, rsp_result, rsp_flags); end
    alu_done = 1'b1; alu_result = 16'hBEEF; alu_flags = 4'b1111;
    @(negedge CLK);
    alu_done = 1'b0;
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_result !== 16'h0000) begin errors++; $display("[TB] FAIL to_stray_done got=%b/%b/%h exp=01/1/0000", rsp_valid, rsp_err, rsp_result); end
    rsp_ready = 2'b01;
    @(negedge CLK);
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL to_rsp_drop got=%b exp=%b", rsp_valid, 2'b00); end
    alu_done = 1'b1; alu_result = 16'hBEEF;
    req_valid = 2'b10; req1_op = 4'd3; req1_a = 16'h00F0; req1_b = 16'h0FF0; #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL to_next_ready got=%b exp=%b", req_ready, 2'b10); end
    @(negedge CLK);
    alu_done = 1'b0; req_valid = 2'b00;
    checks++; if (alu_start !== 1'b1 || alu_a !== 16'h00F0 || alu_op !== 4'd3) begin errors++; $display("[TB] FAIL to_next_issue got=%b/%h/%h exp=1/00f0/3", alu_start, alu_a, alu_op); end
    @(negedge CLK);
    alu_done = 1'b1; alu_result = 16'h0F00; alu_flags = 4'b0000;
    @(negedge CLK);
    alu_done = 1'b0;
    checks++; if (rsp_valid !== 2'b10 || rsp_result !== 16'h0F00 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL to_next_rsp got=%b/%h/%b exp=10/0f00/0", rsp_valid, rsp_result, rsp_err); end
    rsp_ready = 2'b10;
    @(negedge CLK);
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    @(negedge CLK);
    req_valid = 2'b01; req0_op = 4'd2; req0_a = 16'h00FF; req0_b = 16'h0F0F;
    @(negedge CLK);
    req_valid = 2'b00;
    alu_done = 1'b1; alu_result = 16'hDEAD; alu_flags = 4'b1111;
    checks++; if (alu_start !== 1'b1) begin errors++; $display("[TB] FAIL bp_start got=%b exp=%b", alu_start, 1'b1); end
    @(negedge CLK);
    alu_result = 16'h000F; alu_flags = 4'b0001;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL bp_issue_done_ignored got=%b exp=%b", rsp_valid, 2'b00); end
    @(negedge CLK);
    alu_done = 1'b0; req_valid = 2'b10;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (rsp_valid !== 2'b01 || rsp_result !== 16'h000F || rsp_flags !== 4'b0001 || req_ready !== 2'b00) begin errors++; $display("[TB] FAIL bp_hold%0d got=%b/%h/%b/%b exp=01/000f/0001/00", c, rsp_valid, rsp_result, rsp_flags, req_ready); end
      @(negedge CLK);
    end
    rsp_ready = 2'b01;
    @(negedge CLK);
    rsp_ready = 2'b00; #1;
    checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin errors++; $display("[TB] FAIL bp_release got=%b/%b exp=00/10", rsp_valid, req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_in_wait();
    @(negedge CLK);
    req_valid = 2'b01; req0_op = 4'd5; req0_a = 16'h1111; req0_b = 16'h2222; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rw_ready got=%b exp=%b", req_ready, 2'b01); end
    @(negedge CLK);
    req_valid = 2'b00;
    checks++; if (alu_start !== 1'b1) begin errors++; $display("[TB] FAIL rw_start got=%b exp=%b", alu_start, 1'b1); end
    @(negedge CLK);
    RST = 1'b1; req_valid = 2'b11; #1;
    checks++; if (rsp_valid !== 2'b00 || rsp_result !== 16'h0000 || rsp_flags !== 4'b0000 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL rw_rsp_zero got=%b/%h/%b/%b exp=00/0000/0000/0", rsp_valid, rsp_result, rsp_flags, rsp_err); end
    checks++; if (alu_start !== 1'b0 || alu_a !== 16'h0000 || alu_b !== 16'h0000 || alu_op !== 4'd0) begin errors++; $display("[TB] FAIL rw_alu_zero got=%b/%h/%h/%h exp=0/0000/0000/0", alu_start, alu_a, alu_b, alu_op); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL rw_req_ready got=%b exp=%b", req_ready, 2'b00); end
    req_valid = 2'b00;
    @(negedge CLK);
    RST = 1'b0; alu_done = 1'b1; alu_result = 16'h9999; alu_flags = 4'b1010;
    @(negedge CLK);
    alu_done = 1'b0;
    checks++; if (rsp_valid !== 2'b00 || alu_start !== 1'b0) begin errors++; $display("[TB] FAIL rw_done_ignored got=%b/%b exp=00/0", rsp_valid, alu_start); end
    req_valid = 2'b11; req0_op = 4'd0; req0_a = 16'h0001; req0_b = 16'h0001; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rw_tie_grant got=%b exp=%b", req_ready, 2'b01); end
    @(negedge CLK);
    req_valid = 2'b00;
    checks++; if (alu_start !== 1'b1 || alu_a !== 16'h0001) begin errors++; $display("[TB] FAIL rw_issue got=%b/%h exp=1/0001", alu_start, alu_a); end
    @(negedge CLK);
    alu_done = 1'b1; alu_result = 16'h0002; alu_flags = 4'b0000;
    @(negedge CLK);
    alu_done = 1'b0;
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 16'h0002 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL rw_rsp got=%b/%h/%b exp=01/0002/0", rsp_valid, rsp_result, rsp_err); end
    rsp_ready = 2'b01;
    @(negedge CLK);
    rsp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_fairness();
    test_invalid_op();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

endmodule
